// File: rtl/seq_pattern_generator.sv
// Serial pattern transmitter: shifts pattern[pat_len-1:0] out MSB-first, repeat_cnt times (0 = until abort).
// Optional macro SEQ_GEN_GAP_EN inserts GAP_CYCLES idle cycles between repetitions.
module seq_pattern_generator #(
    parameter int PAT_W      = 8,
    parameter int LEN_W      = 4,
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SEQ_GEN_GAP_EN
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam int         GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);
`endif

    // A mis-parameterised instance never accepts a start rather than sending garbage.
    localparam logic CFG_OK = ((2 ** LEN_W) > PAT_W) && (GAP_CYCLES >= 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

    logic [1:0]       state_q,      state_d;
    logic [PAT_W-1:0] pat_q,        pat_d;
    logic [LEN_W-1:0] len_q,        len_d;
    logic [LEN_W-1:0] idx_q,        idx_d;
    logic [CNT_W-1:0] reps_q,       reps_d;
    logic             last_q,       last_d;
    logic             data_out_q,   data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;
`ifdef SEQ_GEN_GAP_EN
    logic [GAP_W-1:0] gap_cnt_q,    gap_cnt_d;
`endif

    logic             accept_s;
    logic [PAT_W-1:0] shifted_s;
    logic             cur_bit_s;

    // Start qualification and current-bit selection.
    always_comb begin
        accept_s  = CFG_OK && start && !abort &&
                    (pat_len != {LEN_W{1'b0}}) && (pat_len <= MAX_LEN);
        shifted_s = pat_q >> idx_q;
        cur_bit_s = shifted_s[0];
    end

    // Next-state and next-output logic; outputs default to the quiet value.
    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        len_d        = len_q;
        idx_d        = idx_q;
        reps_d       = reps_q;
        last_d       = last_q;
        data_out_d   = 1'b0;
        data_valid_d = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef SEQ_GEN_GAP_EN
        gap_cnt_d    = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                last_d = 1'b0;
                if (accept_s) begin
                    state_d = ST_SHIFT;
                    pat_d   = pattern;
                    len_d   = pat_len;
                    idx_d   = pat_len - LEN_W'(1);
                    reps_d  = repeat_cnt;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                end else if (last_q) begin
                    // Final bit went out last cycle: finish with a single done pulse.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    last_d  = 1'b0;
                end else begin
                    data_out_d   = cur_bit_s;
                    data_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    if (idx_q == {LEN_W{1'b0}}) begin
                        idx_d = len_q - LEN_W'(1);
                        if (reps_q == CNT_W'(1)) begin
                            last_d = 1'b1;
                        end else begin
                            if (reps_q != {CNT_W{1'b0}}) begin
                                reps_d = reps_q - CNT_W'(1);
                            end else begin
                                reps_d = reps_q;
                            end
`ifdef SEQ_GEN_GAP_EN
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_INIT;
`else
                            state_d   = ST_SHIFT;
`endif
                        end
                    end else begin
                        idx_d = idx_q - LEN_W'(1);
                    end
                end
            end
`ifdef SEQ_GEN_GAP_EN
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    busy_d = 1'b1;
                    if (gap_cnt_q == {GAP_W{1'b0}}) begin
                        state_d = ST_SHIFT;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pat_q        <= {PAT_W{1'b0}};
            len_q        <= {LEN_W{1'b0}};
            idx_q        <= {LEN_W{1'b0}};
            reps_q       <= {CNT_W{1'b0}};
            last_q       <= 1'b0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
            gap_cnt_q    <= {GAP_W{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            reps_q       <= reps_d;
            last_q       <= last_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SEQ_GEN_GAP_EN
            gap_cnt_q    <= gap_cnt_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Self-checking bench for seq_pattern_generator (default build, gap feature off).
module tb_seq_pattern_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic [7:0] repeat_cnt;
    logic       abort;
    logic       data_out;
    logic       data_valid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_pattern_generator #(
        .PAT_W(8), .LEN_W(4), .CNT_W(8), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .pat_len(pat_len), .repeat_cnt(repeat_cnt), .abort(abort),
        .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input int k, input logic [3:0] exp_v);
        logic [3:0] got;
        got = {data_out, data_valid, busy, done};
        total++;
        assert (got === exp_v) else begin
            bad++;
            $error("FAIL %s cyc=%0d {out,valid,busy,done} got=%b expected=%b", tag, k, got, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transmission: k counts edges after the accepting edge (k=0).
    task automatic tx(input string tag, input logic [7:0] pat, input int len, input int reps,
                      input int kill_at, input bit kill_rst, input bit poke);
        int nbits;
        int k;
        int j;
        bit fin;
        logic [3:0] e;
        nbits      = (reps == 0) ? -1 : reps * len;
        pattern    = pat;
        pat_len    = 4'(len);
        repeat_cnt = 8'(reps);
        abort      = 1'b0;
        reset      = 1'b0;
        start      = 1'b1;
        step();
        start = 1'b0;
        fin   = 1'b0;
        k     = 0;
        while (!fin) begin
            if (kill_at > 0 && k == kill_at) begin
                e   = 4'b0000;
                fin = 1'b1;
            end else if (k == 0) begin
                e = 4'b0010;
            end else begin
                j = k - 1;
                if (nbits < 0 || j < nbits) begin
                    e = {pat[len - 1 - (j % len)], 1'b1, 1'b1, 1'b0};
                end else begin
                    e   = 4'b0001;
                    fin = 1'b1;
                end
            end
            check(tag, k, e);
            abort = 1'b0;
            reset = 1'b0;
            if (!fin && k > 4000) begin
                total++;
                bad++;
                $display("FAIL %s cycle budget exceeded", tag);
                fin = 1'b1;
            end
            if (!fin) begin
                if (poke) begin
                    start      = 1'($urandom_range(0, 1));
                    pattern    = 8'($urandom);
                    pat_len    = 4'($urandom);
                    repeat_cnt = 8'($urandom);
                end
                if (kill_at > 0 && k + 1 == kill_at) begin
                    if (kill_rst) reset = 1'b1;
                    else abort = 1'b1;
                end
                step();
                k++;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
    endtask

    // Drive a start that must be refused and confirm the outputs stay quiet.
    task automatic refused(input string tag, input int len, input bit with_abort, input int n);
        pattern    = 8'h0B;
        pat_len    = 4'(len);
        repeat_cnt = 8'd1;
        start      = 1'b1;
        abort      = with_abort;
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, i, 4'b0000);
        end
        start = 1'b0;
        abort = 1'b0;
        step();
        check(tag, n, 4'b0000);
    endtask

    initial begin
        int len;
        int reps;
        int kill;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        pattern    = 8'h00;
        pat_len    = 4'd0;
        repeat_cnt = 8'd0;
        @(negedge clk);
        step();
        step();
        check("reset", 0, 4'b0000);
        reset = 1'b0;
        step();
        check("post_reset_idle", 0, 4'b0000);

        tx("single_1011", 8'h0B, 4, 1, 0, 1'b0, 1'b0);
        step();
        check("idle_after_done", 0, 4'b0000);
        tx("repeat3_1011", 8'h0B, 4, 3, 0, 1'b0, 1'b0);
        tx("cont_abort9", 8'h0B, 4, 0, 10, 1'b0, 1'b0);
        step();
        check("idle_after_abort", 0, 4'b0000);

        refused("len0", 0, 1'b0, 3);
        refused("len9", 9, 1'b0, 3);
        refused("len15", 15, 1'b0, 2);
        refused("abort_in_idle", 4, 1'b1, 2);

        tx("poke_while_busy", 8'h0B, 4, 2, 0, 1'b0, 1'b1);
        tx("reset_2nd_bit", 8'h0B, 4, 1, 2, 1'b1, 1'b0);
        tx("restart_after_reset", 8'h0B, 4, 1, 0, 1'b0, 1'b0);
        tx("back_to_back", 8'hA7, 8, 1, 0, 1'b0, 1'b0);
        tx("len1_rep3", 8'hFF, 1, 3, 0, 1'b0, 1'b0);
        tx("len8_rep2", 8'h96, 8, 2, 0, 1'b0, 1'b0);
        tx("abort_at_done", 8'hC5, 5, 2, 11, 1'b0, 1'b0);
        tx("abort_first", 8'h5A, 7, 3, 1, 1'b0, 1'b0);
        tx("rep255", 8'h3C, 3, 255, 0, 1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            len  = int'($urandom_range(1, 8));
            reps = int'($urandom_range(0, 5));
            if (reps == 0) kill = int'($urandom_range(1, 40));
            else if ($urandom_range(0, 2) == 0) kill = int'($urandom_range(1, reps * len + 1));
            else kill = 0;
            tx("random", 8'($urandom), len, reps, kill, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                step();
                check("random_idle", it, 4'b0000);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
